// File: rtl/sdram_stream_dma.sv
// sdram_stream_dma: two-channel DMA in front of the SDRAM controller user port.
//   MM2S reads a linear word block from SDRAM into a small FIFO and streams it
//   out on m_t*; S2MM takes words from s_t* through a one-word hold register
//   and writes them linearly. A single arbiter serialises both channels onto
//   the controller, alternating priority between the two after every grant.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rd_start/rd_base/rd_len      MM2S launch; rd_active, rd_done status
//   wr_start/wr_base/wr_len      S2MM launch; wr_active, wr_done status
//   m_tdata/m_tvalid/m_tready/m_tlast   MM2S output stream
//   s_tdata/s_tvalid/s_tready           S2MM input stream
//   ctl_addr/ctl_rw/ctl_wdata/ctl_in_valid   requests to the controller
//   ctl_busy/ctl_rdata/ctl_out_valid         responses from the controller
// Optional build macro SDMA_PERF_CNT_EN adds perf_stall_cnt, a saturating
// count of stream stall cycles.
`timescale 1ns/1ps
module sdram_stream_dma #(
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_start,
   input  logic [ADDR_WIDTH-1:0] rd_base,
   input  logic [LEN_WIDTH-1:0]  rd_len,
   output logic                  rd_active,
   output logic                  rd_done,
   input  logic                  wr_start,
   input  logic [ADDR_WIDTH-1:0] wr_base,
   input  logic [LEN_WIDTH-1:0]  wr_len,
   output logic                  wr_active,
   output logic                  wr_done,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [ADDR_WIDTH-1:0] ctl_addr,
   output logic                  ctl_rw,
   output logic [DATA_WIDTH-1:0] ctl_wdata,
   output logic                  ctl_in_valid,
   input  logic                  ctl_busy,
   input  logic [DATA_WIDTH-1:0] ctl_rdata,
   input  logic                  ctl_out_valid
`ifdef SDMA_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cnt
`endif
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_R_ISSUE, S_R_WAIT, S_W_ISSUE, S_W_GUARD} state_e;

   state_e state_q, state_d;
   logic   prio_rd_q, prio_rd_d;
   logic   grant_rd, grant_wr;

   logic                  rd_active_q, rd_done_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [LEN_WIDTH-1:0]  rd_issue_rem_q, rd_deliv_rem_q;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         fifo_wp_q, fifo_rp_q;
   logic [CW-1:0]         fifo_cnt_q;

   logic                  wr_active_q, wr_done_q, hold_full_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [LEN_WIDTH-1:0]  wr_accept_rem_q, wr_issue_rem_q;
   logic [DATA_WIDTH-1:0] hold_q;

   logic [ADDR_WIDTH-1:0] ctl_addr_q;
   logic [DATA_WIDTH-1:0] ctl_wdata_q;

   logic rd_start_ok, wr_start_ok, fifo_push, fifo_pop, rd_elig, wr_elig, s_hs, wr_finish;

   assign rd_start_ok = rd_start & ~rd_active_q;
   assign wr_start_ok = wr_start & ~wr_active_q;
   // Returned data is only taken while a read is actually outstanding.
   assign fifo_push   = (state_q == S_R_WAIT) & ctl_out_valid;
   assign m_tvalid    = (fifo_cnt_q != '0);
   assign fifo_pop    = m_tvalid & m_tready;
   // Words leave in issue order, so the head is final when one word remains.
   assign m_tlast     = m_tvalid & (rd_deliv_rem_q == LEN_WIDTH'(1));
   assign m_tdata     = m_tvalid ? fifo_mem[fifo_rp_q] : '0;
   // Grants happen only in IDLE, so no read is in flight when this is tested.
   assign rd_elig     = rd_active_q & (rd_issue_rem_q != '0) & (fifo_cnt_q < DEPTH_C);
   assign wr_elig     = hold_full_q;
   assign s_tready    = wr_active_q & ~hold_full_q & (wr_accept_rem_q != '0);
   assign s_hs        = s_tvalid & s_tready;
   assign wr_finish   = (state_q == S_IDLE) & ~ctl_busy & wr_active_q & (wr_issue_rem_q == '0);

   assign rd_active    = rd_active_q;
   assign rd_done      = rd_done_q;
   assign wr_active    = wr_active_q;
   assign wr_done      = wr_done_q;
   assign ctl_addr     = ctl_addr_q;
   assign ctl_wdata    = ctl_wdata_q;
   assign ctl_in_valid = (state_q == S_R_ISSUE) | (state_q == S_W_ISSUE);
   assign ctl_rw       = (state_q == S_W_ISSUE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         prio_rd_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         prio_rd_q <= prio_rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prio_rd_d = prio_rd_q;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!ctl_busy) begin
               if (rd_elig && (!wr_elig || prio_rd_q)) grant_rd = 1'b1;
               else if (wr_elig)                       grant_wr = 1'b1;
               if (grant_rd)      state_d = S_R_ISSUE;
               else if (grant_wr) state_d = S_W_ISSUE;
               if (grant_rd || grant_wr) prio_rd_d = ~prio_rd_q;
            end
         end
         S_R_ISSUE: state_d = S_R_WAIT;
         S_R_WAIT:  if (ctl_out_valid) state_d = S_IDLE;
         S_W_ISSUE: state_d = S_W_GUARD;
         S_W_GUARD: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Request address/data are captured at grant and held until the next grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_addr_q  <= '0;
         ctl_wdata_q <= '0;
      end else if (grant_rd) begin
         ctl_addr_q  <= rd_addr_q;
      end else if (grant_wr) begin
         ctl_addr_q  <= wr_addr_q;
         ctl_wdata_q <= hold_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_active_q    <= 1'b0;
         rd_done_q      <= 1'b0;
         rd_addr_q      <= '0;
         rd_issue_rem_q <= '0;
         rd_deliv_rem_q <= '0;
      end else begin
         rd_done_q <= 1'b0;
         if (rd_start_ok) begin
            rd_addr_q      <= rd_base;
            rd_issue_rem_q <= rd_len;
            rd_deliv_rem_q <= rd_len;
            if (rd_len == '0) rd_done_q   <= 1'b1;
            else              rd_active_q <= 1'b1;
         end else begin
            if (grant_rd) begin
               rd_addr_q      <= rd_addr_q + ADDR_WIDTH'(1);
               rd_issue_rem_q <= rd_issue_rem_q - LEN_WIDTH'(1);
            end
            if (fifo_pop) begin
               rd_deliv_rem_q <= rd_deliv_rem_q - LEN_WIDTH'(1);
               if (m_tlast) begin
                  rd_active_q <= 1'b0;
                  rd_done_q   <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[fifo_wp_q] <= ctl_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_wp_q  <= '0;
         fifo_rp_q  <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (fifo_push) fifo_wp_q <= fifo_wp_q + PW'(1);
         if (fifo_pop)  fifo_rp_q <= fifo_rp_q + PW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_active_q     <= 1'b0;
         wr_done_q       <= 1'b0;
         hold_full_q     <= 1'b0;
         hold_q          <= '0;
         wr_addr_q       <= '0;
         wr_accept_rem_q <= '0;
         wr_issue_rem_q  <= '0;
      end else begin
         wr_done_q <= 1'b0;
         if (wr_start_ok) begin
            wr_addr_q       <= wr_base;
            wr_accept_rem_q <= wr_len;
            wr_issue_rem_q  <= wr_len;
            if (wr_len == '0) wr_done_q   <= 1'b1;
            else              wr_active_q <= 1'b1;
         end else begin
            if (s_hs) begin
               hold_q          <= s_tdata;
               hold_full_q     <= 1'b1;
               wr_accept_rem_q <= wr_accept_rem_q - LEN_WIDTH'(1);
            end
            if (grant_wr) begin
               wr_addr_q      <= wr_addr_q + ADDR_WIDTH'(1);
               wr_issue_rem_q <= wr_issue_rem_q - LEN_WIDTH'(1);
            end
            if (state_q == S_W_ISSUE) hold_full_q <= 1'b0;
            if (wr_finish) begin
               wr_active_q <= 1'b0;
               wr_done_q   <= 1'b1;
            end
         end
      end
   end

`ifdef SDMA_PERF_CNT_EN
   logic        stall;
   logic [31:0] perf_q;
   assign stall          = (m_tvalid & ~m_tready) | (s_tvalid & ~s_tready & wr_active_q);
   assign perf_stall_cnt = perf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            perf_q <= '0;
      else if (rd_start_ok || wr_start_ok) perf_q <= '0;
      else if (stall && (perf_q != '1))    perf_q <= perf_q + 32'd1;
   end
`endif

endmodule

// File: doc/sdram_stream_dma.md
Name: sdram_stream_dma

Overview:
- Two-channel DMA engine sitting directly upstream of the SDRAM controller; it is the sole driver of the controller's user interface (address, rw, write data, in_valid) and the sole consumer of its read data, busy and out_valid.
- MM2S channel: reads a linear block of words from SDRAM and presents it as a valid/ready stream, feeding the FIR datapath.
- S2MM channel: accepts a valid/ready stream, such as FIR results, and writes it linearly into SDRAM.
- A single request arbiter serialises both channels onto the controller.

Parameters:
- ADDR_WIDTH, 23, controller word-address width.
- DATA_WIDTH, 32, data word width.
- LEN_WIDTH, 16, transfer-length counter width in words.
- FIFO_DEPTH, 8, MM2S read-data FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rd_start  in  1  one-cycle pulse; launches an MM2S transfer
- rd_base  in  ADDR_WIDTH  MM2S start word address, sampled on rd_start
- rd_len  in  LEN_WIDTH  MM2S word count, sampled on rd_start
- rd_active  out  1  MM2S transfer in progress
- rd_done  out  1  one-cycle pulse; MM2S complete
- wr_start  in  1  one-cycle pulse; launches an S2MM transfer
- wr_base  in  ADDR_WIDTH  S2MM start word address
- wr_len  in  LEN_WIDTH  S2MM word count
- wr_active  out  1  S2MM transfer in progress
- wr_done  out  1  one-cycle pulse; S2MM complete
- m_tdata  out  DATA_WIDTH  MM2S stream data
- m_tvalid  out  1  MM2S stream valid
- m_tready  in  1  MM2S stream ready
- m_tlast  out  1  final word of the MM2S transfer
- s_tdata  in  DATA_WIDTH  S2MM stream data
- s_tvalid  in  1  S2MM stream valid
- s_tready  out  1  S2MM stream ready
- ctl_addr  out  ADDR_WIDTH  to controller user_addr
- ctl_rw  out  1  to controller rw (1 = write)
- ctl_wdata  out  DATA_WIDTH  to controller write-data input
- ctl_in_valid  out  1  to controller in_valid (one-cycle pulse)
- ctl_busy  in  1  from controller busy
- ctl_rdata  in  DATA_WIDTH  from controller read-data output
- ctl_out_valid  in  1  from controller out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - All outputs are 0, with m_tvalid=0 and s_tready=0.
  - FIFO is empty; both channels are idle.
  - Arbiter is in IDLE with priority set to read.
- Reset mid-transfer: the transfer is abandoned and no done pulse is issued. Any controller transaction already in flight is ignored; out_valid is only honoured in R_WAIT.
- Start:
  - rd_start is honoured only while rd_active=0; likewise wr_start only while wr_active=0. A start during an active transfer is ignored.
  - On a honoured start the base and length are latched, and the active output rises on the next cycle.
  - A length of 0 produces no SDRAM access. The done pulse fires the cycle after the start and active never rises.
- Address generation: the address increments by 1 per issued word and wraps from 2^ADDR_WIDTH−1 to 0.
- MM2S eligibility: the channel may issue a read when words remain to issue and fifo_count + 1 ≤ FIFO_DEPTH. At most one read is outstanding.
- S2MM datapath:
  - A one-word hold register sits between the stream and the controller.
  - s_tready = wr_active & hold register empty & words remaining to accept > 0.
  - The register fills on s_tvalid&s_tready. The channel is eligible to issue while the register is full.
- Arbiter FSM:
  - IDLE:
    - Wait until ctl_busy=0 and at least one channel is eligible.
    - If both are eligible, grant the priority holder; priority toggles after every grant.
    - Read grant → R_ISSUE. Write grant → W_ISSUE.
  - R_ISSUE: ctl_in_valid=1 and ctl_rw=0 for exactly one cycle → R_WAIT.
  - R_WAIT: on ctl_out_valid, push ctl_rdata into the FIFO → IDLE. out_valid in any other state is dropped.
  - W_ISSUE:
    - ctl_in_valid=1, ctl_rw=1, ctl_wdata = hold register, for one cycle.
    - The hold register empties → W_GUARD.
  - W_GUARD: one cycle, ignores ctl_busy → IDLE. IDLE then waits for ctl_busy=0.
  - ctl_addr and ctl_wdata are stable from ISSUE until the next ISSUE.
- MM2S stream:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head.
  - m_tlast is high when the head word is the final word of the transfer.
  - Data must be held while m_tvalid & !m_tready.
  - Simultaneous FIFO push and pop leaves the count unchanged.
- Done conditions:
  - rd_done pulses on the handshake of the tlast word; rd_active falls on that same cycle.
  - wr_done pulses the first cycle IDLE observes ctl_busy=0 after the final write issue; wr_active falls on that same cycle.

Optional Feature:
- Macro: SDMA_PERF_CNT_EN
- Defined:
  - Adds output port perf_stall_cnt, 32 bits.
  - Counts cycles in which m_tvalid & !m_tready, or s_tvalid & !s_tready & wr_active.
  - Saturates at 0xFFFFFFFF; cleared by rst and by any honoured rd_start or wr_start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Read 4 words from 0x000010, controller returns 0xA0..0xA3, m_tready=1 → stream 0xA0..0xA3, m_tlast only on 0xA3, one rd_done pulse, ctl_addr 0x10..0x13.
- Write 3 words 0x11,0x22,0x33 to 0x7FFFFE → controller writes at 0x7FFFFE, 0x7FFFFF, 0x000000 (wrap); wr_done after final busy drop.
- rd_len=10, FIFO_DEPTH=8, m_tready=0 → exactly 8 reads issued, then stall; releasing m_tready → remaining 2 reads issued, 10 words delivered in order.
- Both channels eligible and starting together → controller requests alternate R,W,R,W starting with read; no in_valid while ctl_busy=1.
- rd_len=0 → rd_done one cycle after rd_start, zero ctl_in_valid pulses; rd_start while rd_active → ignored, original transfer unaffected.
- rst asserted mid-read with an out_valid arriving afterwards → all outputs 0 immediately, no data pushed, no done pulse.
